// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the raster vector carried from the fetch stage
// to the display stage.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Coordinate field width inside raster_t; covers totals up to 4096.
  localparam int RW = 12;

  typedef struct packed {
    logic          active;
    logic          hsync;
    logic          vsync;
    logic [RW-1:0] h;
    logic [RW-1:0] v;
    logic          line;
    logic          frame;
  } raster_t;

  localparam raster_t RASTER_IDLE = '0;

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Enable-gated register chain with an async-reset idle value; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int  DEPTH = 2,
  parameter type T     = logic,
  parameter T    IDLE  = '0
) (
  input  logic clk_25,
  input  logic rst_n,
  input  logic en,
  input  T     d,
  output T     q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk_25, rst_n, en};
      assign q = d;
    end else begin : g_reg
      T stage [DEPTH];

      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: look-ahead fetch stage plus a display stage delayed
// by LOOKAHEAD enabled cycles so returned pixel data lines up with sync/blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOOKAHEAD = 2,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW       = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic          en,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          sync_b,
  output logic          sync_blank,
  output logic [CW-1:0] hs,
  output logic [CW-1:0] vs,
  output logic          line_start,
  output logic          frame_start
);

  logic [CW-1:0] hcnt, vcnt;
  int            h_i, v_i;
  raster_t       nxt, fetch_r, disp;

  // Compare in int so a sync window ending exactly at 2**CW cannot wrap.
  assign h_i = int'(hcnt);
  assign v_i = int'(vcnt);

  always_comb begin
    nxt        = RASTER_IDLE;
    nxt.active = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    nxt.hsync  = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
    nxt.vsync  = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
    nxt.h      = RW'(hcnt);
    nxt.v      = RW'(vcnt);
    nxt.line   = (hcnt == '0);
    nxt.frame  = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      fetch_r <= RASTER_IDLE;
    end else if (en) begin
      fetch_r <= nxt;
      if (h_i == H_TOTAL - 1) begin
        hcnt <= '0;
        vcnt <= (v_i == V_TOTAL - 1) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  vga_delay_line #(
    .DEPTH (LOOKAHEAD),
    .T     (raster_t),
    .IDLE  (RASTER_IDLE)
  ) u_dly (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .en     (en),
    .d      (fetch_r),
    .q      (disp)
  );

  assign fetch_valid = fetch_r.active;
  assign fetch_x     = fetch_r.h[CW-1:0];
  assign fetch_y     = fetch_r.v[CW-1:0];

  // Idle vector carries hsync/vsync deasserted, so reset drives the inactive level.
  assign vga_hsync   = disp.hsync ^ ~HSYNC_POL;
  assign vga_vsync   = disp.vsync ^ ~VSYNC_POL;
  assign sync_b      = vga_hsync & vga_vsync;
  assign sync_blank  = ~disp.active;
  assign hs          = disp.h[CW-1:0];
  assign vs          = disp.v[CW-1:0];
  assign line_start  = disp.line;
  assign frame_start = disp.frame;

  logic unused_bits;
  assign unused_bits = &{1'b0, fetch_r.h, fetch_r.v, disp.h, disp.v};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench for vga_timing_gen: three configurations checked cycle by
// cycle against a pixel-index reference model through a scoreboard.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hp, vp;
    int la;
  } cfg_t;

  typedef struct packed {
    logic        fv;
    logic [11:0] fx, fy;
    logic        hsync, vsync, sync_b, blank;
    logic [11:0] hs, vs;
    logic        ls, fs;
  } obs_t;

  logic clk_25 = 1'b0;
  logic rst_n, en;
  bit   clk_run = 1'b1;

  int     tests = 0;
  int     fails = 0;
  longint n = 0;
  cfg_t   cfg_a, cfg_b, cfg_c;
  obs_t   q_a[$], q_b[$], q_c[$];

  initial forever begin
    #20;
    if (clk_run) clk_25 = ~clk_25;
  end

  // dut_a: default 640x480, LOOKAHEAD 2
  logic a_fv, a_hsync, a_vsync, a_sb, a_blank, a_ls, a_fs;
  logic [9:0] a_fx, a_fy, a_hs, a_vs;
  vga_timing_gen dut_a (
    .clk_25(clk_25), .rst_n(rst_n), .en(en),
    .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy),
    .vga_hsync(a_hsync), .vga_vsync(a_vsync), .sync_b(a_sb), .sync_blank(a_blank),
    .hs(a_hs), .vs(a_vs), .line_start(a_ls), .frame_start(a_fs));

  // dut_b: tiny raster, positive polarity, LOOKAHEAD 0
  logic b_fv, b_hsync, b_vsync, b_sb, b_blank, b_ls, b_fs;
  logic [3:0] b_fx, b_fy, b_hs, b_vs;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOOKAHEAD(0)
  ) dut_b (
    .clk_25(clk_25), .rst_n(rst_n), .en(en),
    .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy),
    .vga_hsync(b_hsync), .vga_vsync(b_vsync), .sync_b(b_sb), .sync_blank(b_blank),
    .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs));

  // dut_c: tiny uneven raster, negative polarity, LOOKAHEAD 3
  logic c_fv, c_hsync, c_vsync, c_sb, c_blank, c_ls, c_fs;
  logic [3:0] c_fx, c_fy, c_hs, c_vs;
  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOOKAHEAD(3)
  ) dut_c (
    .clk_25(clk_25), .rst_n(rst_n), .en(en),
    .fetch_valid(c_fv), .fetch_x(c_fx), .fetch_y(c_fy),
    .vga_hsync(c_hsync), .vga_vsync(c_vsync), .sync_b(c_sb), .sync_blank(c_blank),
    .hs(c_hs), .vs(c_vs), .line_start(c_ls), .frame_start(c_fs));

  obs_t act_a, act_b, act_c;
  assign act_a = {a_fv, 12'(a_fx), 12'(a_fy), a_hsync, a_vsync, a_sb, a_blank,
                  12'(a_hs), 12'(a_vs), a_ls, a_fs};
  assign act_b = {b_fv, 12'(b_fx), 12'(b_fy), b_hsync, b_vsync, b_sb, b_blank,
                  12'(b_hs), 12'(b_vs), b_ls, b_fs};
  assign act_c = {c_fv, 12'(c_fx), 12'(c_fy), c_hsync, c_vsync, c_sb, c_blank,
                  12'(c_hs), 12'(c_vs), c_ls, c_fs};

  // After k enabled edges the fetch stage shows raster pixel k-1 and the display
  // stage shows pixel k-1-LOOKAHEAD; before the first such pixel a stage is idle.
  function automatic obs_t model(cfg_t c, longint k);
    obs_t   o;
    longint ht, vt, p, m, h, v;
    bit     act, hon, von, ls, fs;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    o = '0;
    if (k >= 1) begin
      p    = (k - 1) % (ht * vt);
      o.fx = 12'(p % ht);
      o.fy = 12'(p / ht);
      o.fv = ((p % ht) < c.ha) && ((p / ht) < c.va);
    end
    m = k - c.la;
    h = 0; v = 0; act = 0; hon = 0; von = 0; ls = 0; fs = 0;
    if (m >= 1) begin
      p   = (m - 1) % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      act = (h < c.ha) && (v < c.va);
      hon = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
      von = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
      ls  = (h == 0);
      fs  = (p == 0);
    end
    o.hsync  = hon ? c.hp : !c.hp;
    o.vsync  = von ? c.vp : !c.vp;
    o.sync_b = o.hsync & o.vsync;
    o.blank  = !act;
    o.hs     = 12'(h);
    o.vs     = 12'(v);
    o.ls     = ls;
    o.fs     = fs;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t n=%0d got=%h want=%h", name, $time, n, got, want);
    end
  endtask

  task automatic step(input bit e);
    @(negedge clk_25);
    en = e;
    if (e) n++;
    q_a.push_back(model(cfg_a, n));
    q_b.push_back(model(cfg_b, n));
    q_c.push_back(model(cfg_c, n));
  endtask

  // Monitor: one expected entry per driven edge, compared after the edge settles.
  obs_t e_a, e_b, e_c;
  always @(posedge clk_25) begin
    #1;
    if (q_a.size() > 0 && q_b.size() > 0 && q_c.size() > 0) begin
      e_a = q_a.pop_front();
      e_b = q_b.pop_front();
      e_c = q_c.pop_front();
      check("dut_a", act_a, e_a);
      check("dut_b", act_b, e_b);
      check("dut_c", act_c, e_c);
    end
  end

  initial begin
    bit stalled;
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
    cfg_b = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0};
    cfg_c = '{6, 1, 3, 2, 3, 2, 1, 1, 1'b0, 1'b0, 3};
    stalled = 1'b0;
    rst_n = 1'b0;
    en    = 1'b0;
    n     = 0;

    repeat (3) @(posedge clk_25);
    #1;
    check("rst_a", act_a, model(cfg_a, 0));
    check("rst_b", act_b, model(cfg_b, 0));
    check("rst_c", act_c, model(cfg_c, 0));
    @(negedge clk_25);
    rst_n = 1'b1;

    // Random enable, plus a scripted 10-cycle stall while dut_a displays hs=300.
    for (int i = 0; i < 2600; i++) begin
      if (!stalled && n == longint'(cfg_a.la + 301)) begin
        stalled = 1'b1;
        repeat (10) step(1'b0);
      end
      step($urandom_range(0, 99) < 85);
    end

    // Asynchronous reset with the clock stopped mid-frame.
    @(posedge clk_25);
    #2;
    clk_run = 1'b0;
    #50;
    rst_n = 1'b0;
    #5;
    check("async_rst_a", act_a, model(cfg_a, 0));
    check("async_rst_b", act_b, model(cfg_b, 0));
    check("async_rst_c", act_c, model(cfg_c, 0));
    en = 1'b0;
    #50;
    rst_n = 1'b1;
    n = 0;
    #20;
    clk_run = 1'b1;

    for (int i = 0; i < 1200; i++) step((i < 900) ? 1'b1 : ($urandom_range(0, 3) != 0));

    @(posedge clk_25);
    #2;
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d want=0", q_a.size() + q_b.size() + q_c.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
